// File: rtl/heat_sweep_ctrl.sv
// Sweep controller: strobes a bank of column solvers, waits for every column to finish a
// step, then streams one heat-index pixel per column with a valid/ready handshake.
module heat_sweep_ctrl #(
  parameter int NCOLS    = 16,
  parameter int ROW_BITS = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic [ROW_BITS:0]     height,
  input  logic [NCOLS-1:0]      col_flag,
  input  logic [32*NCOLS-1:0]   col_node,
  output logic                  start,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [7:0]            pix_x,
  output logic [ROW_BITS:0]     pix_y,
  output logic [7:0]            pix_color,
  output logic                  frame_done,
  output logic [15:0]           iter_count,
  output logic [2:0]            fsm_state
);

  localparam int              CW      = (NCOLS > 1) ? $clog2(NCOLS) : 1;
  localparam logic [7:0]      LAST    = 8'(NCOLS - 1);
  localparam logic [ROW_BITS:0] ROW_ONE = (ROW_BITS + 1)'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    STROBE    = 3'd1,
    SETTLE    = 3'd2,
    WAIT_DONE = 3'd3,
    CAPTURE   = 3'd4,
    STREAM    = 3'd5,
    ADVANCE   = 3'd6
  } state_t;

  state_t                  state;
  logic [ROW_BITS:0]       top_row;
  logic [ROW_BITS:0]       row_cnt;
  logic [7:0]              c;
  logic                    settle_cnt;
  logic [NCOLS-1:0][31:0]  snapshot;
  logic [7:0]              c_next;
  logic [31:0]             next_word;

  // Node value is s4.27; >>>23 leaves 1/16 steps, so +-8.0 spans the full 8-bit index.
  function automatic logic [7:0] heat(input logic [31:0] w);
    logic signed [31:0] s;
    s = $signed(w) >>> 23;
    if (s > 32'sd127)       heat = 8'hFF;
    else if (s < -32'sd128) heat = 8'h00;
    else                    heat = {~s[7], s[6:0]};
  endfunction

  assign c_next    = c + 8'd1;
  assign next_word = snapshot[c_next[CW-1:0]];
  assign pix_x     = c;
  assign fsm_state = state;

  // Handshake: a pixel transfers on any rising edge where pix_valid && pix_ready; while
  // pix_valid is high and pix_ready low, pix_x/pix_y/pix_color hold their values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      top_row    <= '0;
      row_cnt    <= '0;
      c          <= '0;
      settle_cnt <= 1'b0;
      snapshot   <= '0;
      start      <= 1'b0;
      pix_valid  <= 1'b0;
      pix_y      <= '0;
      pix_color  <= '0;
      frame_done <= 1'b0;
      iter_count <= '0;
    end else begin
      start      <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          top_row <= height;
          if (run) state <= STROBE;
        end
        // The registered strobe becomes visible one cycle later, during the first SETTLE cycle.
        STROBE: begin
          start      <= 1'b1;
          settle_cnt <= 1'b0;
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt) state <= WAIT_DONE;
          else            settle_cnt <= 1'b1;
        end
        WAIT_DONE: begin
          if (&col_flag) state <= CAPTURE;
        end
        CAPTURE: begin
          snapshot  <= col_node;
          c         <= '0;
          pix_y     <= row_cnt;
          pix_color <= heat(col_node[31:0]);
          pix_valid <= 1'b1;
          state     <= STREAM;
        end
        STREAM: begin
          if (pix_ready) begin
            if (c == LAST) begin
              pix_valid  <= 1'b0;
              frame_done <= (row_cnt == top_row);
              state      <= ADVANCE;
            end else begin
              c         <= c_next;
              pix_color <= heat(next_word);
            end
          end
        end
        ADVANCE: begin
          if (row_cnt == top_row) begin
            row_cnt    <= '0;
            iter_count <= iter_count + 16'd1;
          end else begin
            row_cnt <= row_cnt + ROW_ONE;
          end
          state <= run ? STROBE : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_heat_sweep_ctrl.sv
// Directed bench for heat_sweep_ctrl with four modelled columns and hand-computed pixels.
module tb_heat_sweep_ctrl;

  localparam int NCOLS    = 4;
  localparam int ROW_BITS = 7;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_STROBE  = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_STREAM  = 3'd5;

  // Columns 3..0; colour tables are packed the same way.
  localparam logic [127:0] PAT_A  = {32'h7FFFFFFF, 32'hC0000000, 32'h00000000, 32'h40000000};
  localparam logic [31:0]  COLS_A = {8'd255, 8'd0, 8'd128, 8'd255};
  localparam logic [127:0] PAT_B  = {32'hC0800000, 32'h3F800000, 32'hFF800000, 32'h00800000};
  localparam logic [31:0]  COLS_B = {8'd1, 8'd255, 8'd127, 8'd129};
  localparam logic [127:0] PAT_C  = {32'h3FFFFFFF, 32'hFFFFFFFF, 32'h01000000, 32'h80000000};
  localparam logic [31:0]  COLS_C = {8'd255, 8'd127, 8'd130, 8'd0};

  logic                clk;
  logic                reset;
  logic                run;
  logic [ROW_BITS:0]   height;
  logic [NCOLS-1:0]    col_flag;
  logic [32*NCOLS-1:0] col_node;
  logic                start;
  logic                pix_valid;
  logic                pix_ready;
  logic [7:0]          pix_x;
  logic [ROW_BITS:0]   pix_y;
  logic [7:0]          pix_color;
  logic                frame_done;
  logic [15:0]         iter_count;
  logic [2:0]          fsm_state;

  heat_sweep_ctrl #(.NCOLS(NCOLS), .ROW_BITS(ROW_BITS)) dut (
    .clk(clk), .reset(reset), .run(run), .height(height), .col_flag(col_flag),
    .col_node(col_node), .start(start), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color), .frame_done(frame_done),
    .iter_count(iter_count), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- column models ----------------
  int dly [NCOLS];
  int ccnt [NCOLS];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      col_flag <= '1;
      for (int i = 0; i < NCOLS; i++) ccnt[i] <= 0;
    end else begin
      for (int i = 0; i < NCOLS; i++) begin
        if (start) begin
          col_flag[i] <= 1'b0;
          ccnt[i]     <= dly[i];
        end else if (ccnt[i] == 1) begin
          col_flag[i] <= 1'b1;
          ccnt[i]     <= 0;
        end else if (ccnt[i] > 0) begin
          ccnt[i] <= ccnt[i] - 1;
        end
      end
    end
  end

  // ---------------- monitors (negedge, away from the active edge) ----------------
  int          cyc = 0;
  int          start_cnt = 0, start_run = 0, start_max = 0, start_cycle = 0;
  int          fd_cnt = 0, cap_cycle = 0;
  logic [3:0]  cap_flags = '0;
  int          hold_obs = 0, stab_viol = 0;
  logic        hold_prev = 1'b0;
  logic [23:0] held = '0;
  logic [23:0] obs_q[$];

  always @(negedge clk) begin
    cyc++;
    if (start) begin
      start_run++;
      if (start_run == 1) begin
        start_cnt++;
        start_cycle = cyc;
      end
      if (start_run > start_max) start_max = start_run;
    end else begin
      start_run = 0;
    end
    if (frame_done) fd_cnt++;
    if (fsm_state == S_CAPTURE) begin
      cap_cycle = cyc;
      cap_flags = col_flag;
    end
    if (hold_prev && pix_valid) begin
      hold_obs++;
      if ({pix_x, pix_y, pix_color} !== held) stab_viol++;
    end
    hold_prev = pix_valid && !pix_ready && !reset;
    held      = {pix_x, pix_y, pix_color};
    if (!reset && pix_valid && pix_ready) obs_q.push_back({pix_x, pix_y, pix_color});
  end

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [23:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_row(input int y, input logic [31:0] cols);
    for (int i = 0; i < NCOLS; i++)
      exp_q.push_back({8'(i), 8'(y), cols[8*i +: 8]});
  endtask

  task automatic check_pixels(input string tag, input int base);
    int n;
    logic [23:0] e, o;
    n = exp_q.size();
    check({tag, "_count"}, 32'(obs_q.size() - base), 32'(n));
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      o = (base + i < obs_q.size()) ? obs_q[base + i] : 24'hxxxxxx;
      check($sformatf("%s_pix%0d", tag, i), 32'(o), 32'(e));
    end
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
    int n;
    n = 0;
    while (fsm_state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_reach_state"}, 32'(fsm_state), 32'(s));
  endtask

  // ---------------- directed sequence ----------------
  int         b_acc, b_start, b_fd, b_hold, n, g;
  logic [7:0] first_y;

  initial begin
    reset = 1'b1; run = 1'b0; height = 8'd3; pix_ready = 1'b1; col_node = PAT_A;
    for (int i = 0; i < NCOLS; i++) dly[i] = 5;
    repeat (3) @(negedge clk);
    check("rst_start",      32'(start),      32'd0);
    check("rst_pix_valid",  32'(pix_valid),  32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_pix_x",      32'(pix_x),      32'd0);
    check("rst_pix_y",      32'(pix_y),      32'd0);
    check("rst_pix_color",  32'(pix_color),  32'd0);
    check("rst_iter",       32'(iter_count), 32'd0);
    check("rst_state",      32'(fsm_state),  32'(S_IDLE));
    @(posedge clk); #1 reset = 1'b0;

    // Full sweep of four rows with saturating colour pattern.
    for (int r = 0; r < 4; r++) push_row(r, COLS_A);
    b_acc = obs_q.size(); b_start = start_cnt; b_fd = fd_cnt;
    @(posedge clk); #1 run = 1'b1;
    n = 0;
    while (!frame_done && n < 400) begin @(negedge clk); n++; end
    check("sweep_frame_done_seen", 32'(frame_done), 32'd1);
    run = 1'b0;
    wait_state("sweep_idle", S_IDLE, 20);
    #1;
    check_pixels("sweep", b_acc);
    check("sweep_fd_count",    32'(fd_cnt - b_fd),       32'd1);
    check("sweep_iter",        32'(iter_count),          32'd1);
    check("sweep_start_count", 32'(start_cnt - b_start), 32'd4);
    check("sweep_start_width", 32'(start_max),           32'd1);

    // Back-pressure: ready toggles 1,0,1,0 while streaming; height 0 ends a sweep per step.
    col_node = PAT_B; height = 8'd0; pix_ready = 1'b0;
    push_row(0, COLS_B);
    b_acc = obs_q.size(); b_start = start_cnt; b_fd = fd_cnt; b_hold = hold_obs;
    @(posedge clk); #1 run = 1'b1;
    wait_state("bp_stream", S_STREAM, 100);
    run = 1'b0;
    g = 0;
    while (fsm_state == S_STREAM && g < 30) begin
      @(posedge clk); #1 pix_ready = ~pix_ready;
      g++;
    end
    pix_ready = 1'b1;
    wait_state("bp_idle", S_IDLE, 20);
    #1;
    check_pixels("bp", b_acc);
    check("bp_hold_obs",     32'(hold_obs - b_hold),   32'd4);
    check("bp_stable",       32'(stab_viol),           32'd0);
    check("bp_fd_count",     32'(fd_cnt - b_fd),       32'd1);
    check("bp_iter",         32'(iter_count),          32'd2);
    check("bp_start_count",  32'(start_cnt - b_start), 32'd1);

    // Slow column 2: capture waits for all flags, no extra strobe meanwhile.
    col_node = PAT_C; dly[2] = 25;
    push_row(0, COLS_C);
    b_acc = obs_q.size(); b_start = start_cnt; b_fd = fd_cnt;
    @(posedge clk); #1 run = 1'b1;
    wait_state("slow_strobe", S_STROBE, 10);
    run = 1'b0;
    wait_state("slow_idle", S_IDLE, 200);
    #1;
    check_pixels("slow", b_acc);
    check("slow_cap_latency", 32'(cap_cycle - start_cycle), 32'd27);
    check("slow_cap_flags",   32'(cap_flags),               32'hF);
    check("slow_start_count", 32'(start_cnt - b_start),     32'd1);
    check("slow_fd_count",    32'(fd_cnt - b_fd),           32'd1);
    check("slow_iter",        32'(iter_count),              32'd3);

    // run dropped during SETTLE: the row still completes, then the FSM parks.
    dly[2] = 5; col_node = PAT_A; height = 8'd3;
    push_row(0, COLS_A);
    b_acc = obs_q.size(); b_start = start_cnt; b_fd = fd_cnt;
    @(posedge clk); #1 run = 1'b1;
    wait_state("drop_settle", S_SETTLE, 10);
    run = 1'b0;
    wait_state("drop_idle", S_IDLE, 100);
    repeat (10) @(negedge clk);
    #1;
    check_pixels("drop", b_acc);
    check("drop_start_count", 32'(start_cnt - b_start), 32'd1);
    check("drop_fd_count",    32'(fd_cnt - b_fd),       32'd0);
    check("drop_iter",        32'(iter_count),          32'd3);
    check("drop_parked",      32'(fsm_state),           32'(S_IDLE));

    // Reset after the second accepted pixel of row 1, then restart from row 0.
    @(posedge clk); #1 run = 1'b1;
    n = 0; g = 0; first_y = 8'hFF;
    while (n < 2 && g < 200) begin
      @(negedge clk);
      if (pix_valid && pix_ready) begin
        if (n == 0) first_y = pix_y;
        n++;
      end
      g++;
    end
    check("mid_accepts",  32'(n),       32'd2);
    check("mid_first_y",  32'(first_y), 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    #1;
    check("async_pix_valid", 32'(pix_valid),  32'd0);
    check("async_iter",      32'(iter_count), 32'd0);
    check("async_state",     32'(fsm_state),  32'(S_IDLE));
    check("async_pix_x",     32'(pix_x),      32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("restart_no_start0", 32'(start), 32'd0);
    @(posedge clk); #1;
    check("restart_strobe",    32'(fsm_state), 32'(S_STROBE));
    check("restart_no_start1", 32'(start),     32'd0);
    @(posedge clk); #1;
    check("restart_start",     32'(start),     32'd1);
    g = 0;
    while (!(pix_valid && pix_ready) && g < 100) begin @(negedge clk); g++; end
    check("restart_valid", 32'(pix_valid), 32'd1);
    check("restart_x",     32'(pix_x),     32'd0);
    check("restart_y",     32'(pix_y),     32'd0);
    check("restart_color", 32'(pix_color), 32'd255);
    run = 1'b0;
    wait_state("final_idle", S_IDLE, 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/heat_sweep_ctrl.md
HEAT_SWEEP_CTRL -- requirements
Module: heat_sweep_ctrl

Interface
REQ-001 Parameter NCOLS, default 16: number of column instances driven.
REQ-002 Parameter ROW_BITS, default 7: row index is [ROW_BITS:0].
REQ-003 clk  in  1  single clock domain; every register is clocked on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 run  in  1  level; while high, sweeps proceed; while low, the block idles after the current step completes.
REQ-006 height  in  ROW_BITS+1  top row index, sampled in IDLE.
REQ-007 col_flag  in  NCOLS  per-column step-complete flags.
REQ-008 col_node  in  32*NCOLS  per-column node_center, signed fixed point (1 sign, 4 integer, 27 fraction bits); column c occupies bits [32c+31:32c].
REQ-009 start  out  1  broadcast step strobe to all columns.
REQ-010 pix_valid  out  1  pixel word available.
REQ-011 pix_ready  in  1  downstream accepts the word when pix_valid&&pix_ready.
REQ-012 pix_x  out  8  column index of the pixel.
REQ-013 pix_y  out  ROW_BITS+1  row index of the pixel.
REQ-014 pix_color  out  8  heat index.
REQ-015 frame_done  out  1  one-cycle pulse at the end of each full sweep.
REQ-016 iter_count  out  16  count of completed sweeps; wraps modulo 2^16.

Function
REQ-017 FSM states: IDLE, STROBE, SETTLE, WAIT_DONE, CAPTURE, STREAM, ADVANCE.
REQ-018 IDLE: latch height into top_row. Go to STROBE when run=1; otherwise stay.
REQ-019 STROBE: drive start=1 for exactly one cycle, clear settle counter, go to SETTLE. start=0 in every other state.
REQ-020 SETTLE: wait 2 cycles (this covers the columns dropping flag), then go to WAIT_DONE.
REQ-021 WAIT_DONE: when &col_flag==1, go to CAPTURE. There is no timeout.
REQ-022 CAPTURE: register the entire col_node bus into a snapshot, set pixel index c=0, set the pixel row to row_cnt, go to STREAM.
REQ-023 Heat index per column: s = snapshot_c >>> 23 (arithmetic shift); clamp s to [-128, 127]; pix_color = s+128, 8 bits.
  - +8.0 maps to 255.
  - 0.0 maps to 128.
  - -8.0 maps to 0.
  - Values beyond ±8 saturate.
REQ-024 STREAM outputs:
  - pix_valid=1.
  - pix_x=c, pix_y=captured row, pix_color=index of column c.
  - All three held stable until accepted.
REQ-025 STREAM advance: on acceptance, c increments; acceptance at c==NCOLS-1 goes to ADVANCE with pix_valid=0 in the next cycle.
REQ-026 Simultaneous valid/ready on consecutive cycles: one pixel is accepted per cycle, with no bubbles between pixels.
REQ-027 ADVANCE, when row_cnt==top_row:
  - row_cnt <= 0.
  - iter_count increments.
  - frame_done=1 for this cycle.
REQ-028 ADVANCE, otherwise: row_cnt increments.
REQ-029 ADVANCE exit: go to STROBE if run=1, else go to IDLE.
REQ-030 run falling while the FSM is in STROBE through STREAM does not abort the step; all NCOLS pixels are still emitted.
REQ-031 height is only resampled in IDLE; changes at any other time are ignored until the next IDLE.
REQ-032 height==0: every step is a sweep boundary, so frame_done pulses after every step.

Reset
REQ-033 Asserting reset forces state=IDLE immediately, without waiting for a clock edge.
REQ-034 Reset values:
  - start=0, pix_valid=0, frame_done=0.
  - pix_x=0, pix_y=0, pix_color=0.
  - iter_count=0, row_cnt=0, c=0.
REQ-035 Reset asserted mid-STREAM drops pix_valid without completing the handshake; no partial pixel is reported after reset.
REQ-036 After reset deasserts, the first start occurs no earlier than 2 cycles after run is seen high in IDLE.

Verification
REQ-037 NCOLS=4, height=3, run=1, column models raise flags 5 cycles after start, pix_ready=1 -> start pulses are exactly 1 cycle wide; rows 0,1,2,3 are emitted in order; frame_done pulses once; iter_count=1.
REQ-038 col_node = {0x40000000, 0x00000000, 0xC0000000, 0x7FFFFFFF}, i.e. columns 0..3 = +8.0, 0.0, -8.0, +15.99 -> pix_color = 255, 128, 0, 255 for pix_x = 0..3.
REQ-039 pix_ready toggled 1,0,1,0 during STREAM -> exactly 4 acceptances; pix_x/pix_y/pix_color stable whenever pix_valid=1 and pix_ready=0.
REQ-040 Column 2 raises its flag 20 cycles later than the others -> CAPTURE occurs only after col_flag=4'hF; no start pulse is issued during the wait.
REQ-041 run dropped in SETTLE -> the current row is still streamed in full (4 pixels), then the FSM enters IDLE and no further start is issued.
REQ-042 Reset asserted after the 2nd pixel is accepted -> pix_valid=0 and iter_count=0 with no clock edge required; the next sweep restarts at row 0, pix_x=0.
